// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder arbiter: FSM encoding and requester ids.
package serial_add_pkg;

  // Number of request ports sharing the serial adder.
  localparam int NUM_REQ = 2;

  // FSM encoding kept as plain constants so older tools and netlists can read it.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Identifies which requester owns an operation.
  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/Adder.sv
// 1-bit full-adder cell; the only arithmetic element in the serial adder.
module Adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  // Sum and carry written as gates so the cell maps straight onto LUTs.
  always_comb begin
    S    = A ^ B ^ Cin;
    Cout = (A & B) | (Cin & (A ^ B));
  end

endmodule

// File: rtl/serial_add_arbiter.sv
// Two-port round-robin front end for a single bit-serial full adder.
// One bit is processed per cycle, LSB first; the result is held on the
// response port until the consumer takes it.
module serial_add_arbiter
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] sum_sh_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    inc_c;
  req_id_t          id_reg;
  req_id_t          last_grant_reg;

  logic             gnt_valid;
  req_id_t          gnt_id;
  logic             add_s;
  logic             add_cout;

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not
  // served last.
  function automatic logic [1:0] pick_grant(input logic v0, input logic v1,
                                            input req_id_t last);
    if (v0 && v1) return {1'b1, ~last};
    else if (v0)  return 2'b10;
    else if (v1)  return 2'b11;
    else          return 2'b00;
  endfunction

  // Grant is only meaningful in IDLE; the ready outputs mask it elsewhere.
  always_comb begin
    {gnt_valid, gnt_id} = pick_grant(req0_valid, req1_valid, last_grant_reg);
  end

  assign req0_ready = (state_reg == IDLE) && gnt_valid && (gnt_id == 1'b0) && rst_n;
  assign req1_ready = (state_reg == IDLE) && gnt_valid && (gnt_id == 1'b1) && rst_n;

  assign rsp_valid = (state_reg == DONE);
  assign rsp_sum   = sum_sh_reg;
  assign rsp_cout  = carry_reg;
  assign rsp_id    = id_reg;

  // Bit counter increment built as a ripple half-adder chain so the full
  // adder cell stays the only arithmetic in the datapath.
  assign inc_c[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < CW; gi++) begin : g_cnt_inc
      assign cnt_next[gi] = cnt_reg[gi] ^ inc_c[gi];
      if (gi < CW - 1) begin : g_carry
        assign inc_c[gi+1] = cnt_reg[gi] & inc_c[gi];
      end
    end
  endgenerate

  Adder u_adder (
    .A    (a_sh_reg[0]),
    .B    (b_sh_reg[0]),
    .Cin  (carry_reg),
    .S    (add_s),
    .Cout (add_cout)
  );

  // FSM and shift datapath: load on accept, one bit per RUN cycle, hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      a_sh_reg       <= '0;
      b_sh_reg       <= '0;
      sum_sh_reg     <= '0;
      carry_reg      <= 1'b0;
      cnt_reg        <= '0;
      id_reg         <= '0;
      last_grant_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (gnt_valid) begin
            a_sh_reg       <= gnt_id ? req1_a   : req0_a;
            b_sh_reg       <= gnt_id ? req1_b   : req0_b;
            carry_reg      <= gnt_id ? req1_cin : req0_cin;
            cnt_reg        <= '0;
            id_reg         <= gnt_id;
            last_grant_reg <= gnt_id;
            state_reg      <= RUN;
          end
        end
        RUN: begin
          a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
          sum_sh_reg <= {add_s, sum_sh_reg[WIDTH-1:1]};
          carry_reg  <= add_cout;
          cnt_reg    <= cnt_next;
          if (cnt_reg == CNT_LAST) state_reg <= DONE;
        end
        DONE: begin
          if (rsp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter: an 8-bit instance for most scenarios
// and a 4-bit instance for the narrow-width case.
module tb_serial_add_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       req0_cin = 1'b0, req1_cin = 1'b0;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_id, rsp_cout;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_sum;

  logic       w4_valid = 1'b0;
  logic [3:0] w4_a = '0, w4_b = '0;
  logic       w4_cin = 1'b0;
  logic       w4_ready, w4_r1_ready;
  logic       w4_rsp_valid, w4_rsp_id, w4_rsp_cout;
  logic [3:0] w4_rsp_sum;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_add_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  serial_add_arbiter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(w4_valid), .req0_a(w4_a), .req0_b(w4_b), .req0_cin(w4_cin),
    .req0_ready(w4_ready),
    .req1_valid(1'b0), .req1_a(4'h0), .req1_b(4'h0), .req1_cin(1'b0),
    .req1_ready(w4_r1_ready),
    .rsp_valid(w4_rsp_valid), .rsp_ready(1'b1), .rsp_id(w4_rsp_id),
    .rsp_sum(w4_rsp_sum), .rsp_cout(w4_rsp_cout)
  );

  // Reset pulse ending on a falling edge with all requests idle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at the falling edge just after an accept; returns how many cycles
  // until rsp_valid is seen (1 = first cycle after accept), or -1 on timeout.
  task automatic wait_rsp(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      if (rsp_valid === 1'b1) begin
        k = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (rsp_sum !== 8'h00) begin n_bad++; $display("FAIL reset_rsp_sum: got %h expected 00", rsp_sum); end
    n_cmp++; if (rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin n_bad++; $display("FAIL reset_cout_id: got %b/%b expected 0/0", rsp_cout, rsp_id); end
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_readys: got %b expected 00", {req0_ready, req1_ready}); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn reset done");
  endtask

  task automatic test_req0();
    int k;
    do_reset();
    req0_a = 8'h35; req0_b = 8'h4A; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL req0_ready: got %b expected 10", {req0_ready, req1_ready}); end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp(k);
    n_cmp++; if (k !== 9) begin n_bad++; $display("FAIL req0_latency: got %0d expected 9", k); end
    n_cmp++; if (rsp_sum !== 8'h7F || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin n_bad++; $display("FAIL req0_result: got sum=%h cout=%b id=%b expected 7f/0/0", rsp_sum, rsp_cout, rsp_id); end
    $display("txn req0 0x35+0x4A sum=%h cout=%b id=%b", rsp_sum, rsp_cout, rsp_id);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_sum !== 8'h7F) begin n_bad++; $display("FAIL req0_after_hs: got valid=%b sum=%h expected 0/7f", rsp_valid, rsp_sum); end
  endtask

  task automatic test_req1();
    int k;
    req1_a = 8'hFF; req1_b = 8'h01; req1_cin = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_bad++; $display("FAIL req1_ready: got %b expected 01", {req0_ready, req1_ready}); end
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(k);
    n_cmp++; if (k !== 9) begin n_bad++; $display("FAIL req1_latency: got %0d expected 9", k); end
    n_cmp++; if (rsp_sum !== 8'h01 || rsp_cout !== 1'b1 || rsp_id !== 1'b1) begin n_bad++; $display("FAIL req1_result: got sum=%h cout=%b id=%b expected 01/1/1", rsp_sum, rsp_cout, rsp_id); end
    $display("txn req1 0xFF+0x01+1 sum=%h cout=%b id=%b", rsp_sum, rsp_cout, rsp_id);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int acc_id[4];
    int acc_cyc[4];
    int n_acc = 0;
    int n_rsp = 0;
    logic both_high = 1'b0;
    logic bad_sum = 1'b0;
    logic bad_rid = 1'b0;
    do_reset();
    req0_a = 8'h10; req0_b = 8'h20; req0_cin = 1'b0;   // 0x30, cout 0
    req1_a = 8'h80; req1_b = 8'h80; req1_cin = 1'b1;   // 0x01, cout 1
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (req0_ready && req1_ready) both_high = 1'b1;
      if ((req0_ready || req1_ready) && n_acc < 4) begin
        acc_id[n_acc]  = req1_ready ? 1 : 0;
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (rsp_valid === 1'b1) begin
        if (rsp_id !== n_rsp[0]) bad_rid = 1'b1;
        if (rsp_id === 1'b0 && {rsp_cout, rsp_sum} !== 9'h030) bad_sum = 1'b1;
        if (rsp_id === 1'b1 && {rsp_cout, rsp_sum} !== 9'h101) bad_sum = 1'b1;
        $display("txn b2b rsp id=%b sum=%h cout=%b", rsp_id, rsp_sum, rsp_cout);
        n_rsp++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_cmp++; if (both_high !== 1'b0) begin n_bad++; $display("FAIL b2b_one_ready: got both readys high expected one"); end
    n_cmp++; if (n_acc !== 4) begin n_bad++; $display("FAIL b2b_accepts: got %0d expected 4", n_acc); end
    n_cmp++; if (n_rsp !== 4) begin n_bad++; $display("FAIL b2b_responses: got %0d expected 4", n_rsp); end
    n_cmp++; if (bad_sum !== 1'b0 || bad_rid !== 1'b0) begin n_bad++; $display("FAIL b2b_rsp: got bad_sum=%b bad_id=%b expected 0/0", bad_sum, bad_rid); end
    for (int i = 0; i < n_acc; i++) begin
      n_cmp++; if (acc_id[i] !== (i % 2)) begin n_bad++; $display("FAIL b2b_grant_%0d: got id %0d expected %0d", i, acc_id[i], i % 2); end
      n_cmp++; if (acc_cyc[i] !== 10 * i) begin n_bad++; $display("FAIL b2b_cycle_%0d: got %0d expected %0d", i, acc_cyc[i], 10 * i); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int k;
    logic held_bad = 1'b0;
    do_reset();
    rsp_ready = 1'b0;
    req0_a = 8'h35; req0_b = 8'h4A; req0_cin = 1'b0;   // 0x7F
    req1_a = 8'h12; req1_b = 8'h34; req1_cin = 1'b0;   // 0x46
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL bp_first_tie: got %b expected 10", {req0_ready, req1_ready}); end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp(k);
    n_cmp++; if (k !== 9) begin n_bad++; $display("FAIL bp_latency: got %0d expected 9", k); end
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rsp_valid !== 1'b1 || rsp_sum !== 8'h7F || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) held_bad = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (held_bad !== 1'b0) begin n_bad++; $display("FAIL bp_hold: got unstable DONE outputs expected valid=1 sum=7f id=0 readys=00"); end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b1 || req1_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hs_cycle: got valid=%b r1=%b expected 1/0", rsp_valid, req1_ready); end
    $display("txn bp rsp id=%b sum=%h", rsp_id, rsp_sum);
    @(negedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || req1_ready !== 1'b1 || rsp_sum !== 8'h7F) begin n_bad++; $display("FAIL bp_next_accept: got valid=%b r1=%b sum=%h expected 0/1/7f", rsp_valid, req1_ready, rsp_sum); end
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(k);
    n_cmp++; if (k !== 9 || rsp_sum !== 8'h46 || rsp_id !== 1'b1 || rsp_cout !== 1'b0) begin n_bad++; $display("FAIL bp_second: got k=%0d sum=%h id=%b cout=%b expected 9/46/1/0", k, rsp_sum, rsp_id, rsp_cout); end
    $display("txn bp rsp id=%b sum=%h", rsp_id, rsp_sum);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int k;
    logic spurious = 1'b0;
    do_reset();
    req0_a = 8'h35; req0_b = 8'h4A; req0_cin = 1'b0;
    req1_a = 8'h01; req1_b = 8'h02; req1_cin = 1'b0;
    req0_valid = 1'b1;
    @(posedge clk);          // accept req0, last grant becomes 0
    @(negedge clk);          // RUN cycle 1
    req0_valid = 1'b0;
    @(negedge clk);          // RUN cycle 2
    @(negedge clk);          // RUN cycle 3
    @(negedge clk);          // RUN cycle 4
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || {req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL mid_reset_ctrl: got valid=%b readys=%b expected 0/00", rsp_valid, {req0_ready, req1_ready}); end
    n_cmp++; if (rsp_sum !== 8'h00 || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin n_bad++; $display("FAIL mid_reset_data: got sum=%h cout=%b id=%b expected 00/0/0", rsp_sum, rsp_cout, rsp_id); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) spurious = 1'b1;
    end
    n_cmp++; if (spurious !== 1'b0) begin n_bad++; $display("FAIL mid_reset_no_rsp: got rsp_valid=1 expected 0"); end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL mid_reset_tie: got %b expected 10", {req0_ready, req1_ready}); end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(k);
    n_cmp++; if (k !== 9 || rsp_id !== 1'b0 || rsp_sum !== 8'h7F) begin n_bad++; $display("FAIL mid_reset_after: got k=%0d id=%b sum=%h expected 9/0/7f", k, rsp_id, rsp_sum); end
    $display("txn mid-reset follow-up id=%b sum=%h", rsp_id, rsp_sum);
    @(negedge clk);
  endtask

  task automatic test_width4();
    int k = -1;
    do_reset();
    w4_a = 4'hF; w4_b = 4'hF; w4_cin = 1'b1; w4_valid = 1'b1;
    #1;
    n_cmp++; if (w4_ready !== 1'b1) begin n_bad++; $display("FAIL w4_ready: got %b expected 1", w4_ready); end
    @(posedge clk);
    @(negedge clk);
    w4_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (w4_rsp_valid === 1'b1) begin
        k = i;
        break;
      end
      @(negedge clk);
    end
    n_cmp++; if (k !== 5) begin n_bad++; $display("FAIL w4_latency: got %0d expected 5", k); end
    n_cmp++; if (w4_rsp_sum !== 4'hF || w4_rsp_cout !== 1'b1 || w4_rsp_id !== 1'b0) begin n_bad++; $display("FAIL w4_result: got sum=%h cout=%b id=%b expected f/1/0", w4_rsp_sum, w4_rsp_cout, w4_rsp_id); end
    $display("txn w4 0xF+0xF+1 sum=%h cout=%b", w4_rsp_sum, w4_rsp_cout);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_req0();
    test_req1();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_width4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
